// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest legal data word; narrower words are zero-extended before parity.
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop1,
        TxStop2
    } tx_state_e;

    // XOR of all data bits, i.e. the bit that makes the word even.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator shared by the RX and TX state machines.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    // Down-counter reloading on terminal count; a zero divisor ticks every cycle.
    always_comb begin
        cnt_d = cnt_q - DIV_W'(1);
        if (cnt_q == '0) begin
            cnt_d = (divisor == '0) ? '0 : divisor - DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver: shared baud tick, independent RX and TX FSMs.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DIV_W-1:0]     divisor,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_ready,
    output logic                 tx_done
);

    localparam int unsigned OSW  = $clog2(OVERSAMPLE);
    localparam int unsigned IDXW = $clog2(DATA_BITS);
    localparam logic [OSW-1:0]  OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0]  HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [IDXW-1:0] BIT_LAST  = IDXW'(DATA_BITS - 1);

    logic tick;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .divisor   (divisor),
        .tick      (tick)
    );

    // ---------------------------------------------------------------- RX ---
    logic [1:0]           rx_sync_q;
    logic                 rx_line;
    rx_state_e            rx_state_q, rx_state_d;
    logic [OSW-1:0]       rx_cnt_q, rx_cnt_d;
    logic [IDXW-1:0]      rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]           rx_par_q, rx_par_d;
    logic                 rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_parity_err_q, rx_parity_err_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_sample;

    assign rx_line = rx_sync_q[1];

    // RX next state: mid-bit sampling, half a bit after start detection then every bit.
    always_comb begin
        rx_state_d      = rx_state_q;
        rx_cnt_d        = rx_cnt_q;
        rx_idx_d        = rx_idx_q;
        rx_shift_d      = rx_shift_q;
        rx_par_d        = rx_par_q;
        rx_perr_d       = rx_perr_q;
        rx_data_d       = rx_data_q;
        rx_done_d       = 1'b0;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;
        rx_sample       = tick && (rx_cnt_q == ((rx_state_q == RxStart) ? HALF_LAST : OS_LAST));

        if (tick && (rx_state_q != RxIdle) && (rx_state_q != RxWaitHigh)) begin
            rx_cnt_d = rx_sample ? '0 : rx_cnt_q + OSW'(1);
        end

        case (rx_state_q)
            RxIdle: begin
                if (tick && !rx_line) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                    rx_par_d   = parity_mode;
                    rx_perr_d  = 1'b0;
                end
            end
            RxStart: begin
                if (rx_sample) begin
                    // Line back high at mid-start: treat as a glitch.
                    rx_state_d = rx_line ? RxIdle : RxData;
                    rx_idx_d   = '0;
                end
            end
            RxData: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == BIT_LAST) begin
                        rx_state_d = parity_enabled(rx_par_q) ? RxParity : RxStop;
                    end else begin
                        rx_idx_d = rx_idx_q + IDXW'(1);
                    end
                end
            end
            RxParity: begin
                if (rx_sample) begin
                    rx_perr_d  = rx_line ^ even_parity(MAX_DATA_BITS'(rx_shift_q))
                                 ^ (rx_par_q == PAR_ODD);
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_sample) begin
                    rx_data_d       = rx_shift_q;
                    rx_done_d       = 1'b1;
                    rx_parity_err_d = rx_perr_q;
                    rx_frame_err_d  = !rx_line;
                    rx_state_d      = rx_line ? RxIdle : RxWaitHigh;
                end
            end
            RxWaitHigh: begin
                // Hold off until the line recovers so a break reports only once.
                if (tick && rx_line) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX registers, including the input synchroniser.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sync_q       <= 2'b11;
            rx_state_q      <= RxIdle;
            rx_cnt_q        <= '0;
            rx_idx_q        <= '0;
            rx_shift_q      <= '0;
            rx_par_q        <= PAR_NONE;
            rx_perr_q       <= 1'b0;
            rx_data_q       <= '0;
            rx_done_q       <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            rx_sync_q       <= {rx_sync_q[0], uart_rx};
            rx_state_q      <= rx_state_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_idx_q        <= rx_idx_d;
            rx_shift_q      <= rx_shift_d;
            rx_par_q        <= rx_par_d;
            rx_perr_q       <= rx_perr_d;
            rx_data_q       <= rx_data_d;
            rx_done_q       <= rx_done_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;

    // ---------------------------------------------------------------- TX ---
    tx_state_e            tx_state_q, tx_state_d;
    logic [OSW-1:0]       tx_cnt_q, tx_cnt_d;
    logic                 tx_arm_q, tx_arm_d;
    logic [IDXW-1:0]      tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_bit_q, tx_par_bit_d;
    logic                 tx_par_en_q, tx_par_en_d;
    logic                 tx_stop2_q, tx_stop2_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_accept;
    logic                 tx_bit_end;

    // A write coinciding with the tx_done cycle is dropped.
    assign tx_accept  = tx_wr && (tx_state_q == TxIdle) && !tx_done_q;
    assign tx_bit_end = tick && tx_arm_q && (tx_cnt_q == OS_LAST);

    // TX next state: the line value for each bit is set on the edge that enters it.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_arm_d     = tx_arm_q;
        tx_idx_d     = tx_idx_q;
        tx_shift_d   = tx_shift_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_par_en_d  = tx_par_en_q;
        tx_stop2_d   = tx_stop2_q;
        tx_line_d    = tx_line_q;
        tx_done_d    = 1'b0;

        // First tick after acceptance only aligns the bit phase.
        if (tick && (tx_state_q != TxIdle)) begin
            if (!tx_arm_q) begin
                tx_arm_d = 1'b1;
            end else begin
                tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + OSW'(1);
            end
        end

        case (tx_state_q)
            TxIdle: begin
                if (tx_accept) begin
                    tx_shift_d   = tx_data;
                    tx_par_bit_d = even_parity(MAX_DATA_BITS'(tx_data)) ^ (parity_mode == PAR_ODD);
                    tx_par_en_d  = parity_enabled(parity_mode);
                    tx_stop2_d   = stop2;
                    tx_line_d    = 1'b0;
                    tx_cnt_d     = '0;
                    tx_arm_d     = 1'b0;
                    tx_state_d   = TxStart;
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_idx_d   = '0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == BIT_LAST) begin
                        tx_line_d  = tx_par_en_q ? tx_par_bit_q : 1'b1;
                        tx_state_d = tx_par_en_q ? TxParity : TxStop1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                        tx_idx_d   = tx_idx_q + IDXW'(1);
                    end
                end
            end
            TxParity: begin
                if (tx_bit_end) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = TxStop1;
                end
            end
            TxStop1: begin
                if (tx_bit_end) begin
                    tx_state_d = tx_stop2_q ? TxStop2 : TxIdle;
                    tx_done_d  = !tx_stop2_q;
                end
            end
            TxStop2: begin
                if (tx_bit_end) begin
                    tx_state_d = TxIdle;
                    tx_done_d  = 1'b1;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // TX registers; line idles high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q   <= TxIdle;
            tx_cnt_q     <= '0;
            tx_arm_q     <= 1'b0;
            tx_idx_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_bit_q <= 1'b0;
            tx_par_en_q  <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_line_q    <= 1'b1;
            tx_done_q    <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_arm_q     <= tx_arm_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_line_q    <= tx_line_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign uart_tx  = tx_line_q;
    assign tx_ready = (tx_state_q == TxIdle);
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: TX waveform, loopback, RX errors, break, glitch, reset.
module tb_uart_xcvr;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DIV_W      = 16;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic [DIV_W-1:0]     divisor = 16'd4;
    logic [1:0]           parity_mode = 2'b00;
    logic                 stop2 = 1'b0;
    logic                 uart_rx;
    logic                 uart_tx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic                 tx_wr = 1'b0;
    logic                 tx_ready;
    logic                 tx_done;

    logic loop_en = 1'b0;
    logic rx_drv  = 1'b1;
    assign uart_rx = loop_en ? uart_tx : rx_drv;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;

    always #5 sys_clk = ~sys_clk;

    uart_xcvr #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_W      (DIV_W)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .divisor       (divisor),
        .parity_mode   (parity_mode),
        .stop2         (stop2),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .tx_data       (tx_data),
        .tx_wr         (tx_wr),
        .tx_ready      (tx_ready),
        .tx_done       (tx_done)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (rx_done === 1'b1) rx_cnt++;
        if (tx_done === 1'b1) tx_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [DATA_BITS-1:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge sys_clk);
        tx_wr   = 1'b0;
    endtask

    task automatic wait_tx_level(input logic lvl, input int limit, output int w);
        w = 0;
        while (uart_tx !== lvl && w < limit) begin
            @(negedge sys_clk);
            w++;
        end
    endtask

    // Drive a frame LSB first, 64 cycles per bit (divisor 4).
    task automatic drive_frame(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (64) @(negedge sys_clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int w;
        int rx_base;
        int tx_base;
        logic [8:0] exp_a5;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_done", rx_done, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_flags", {rx_parity_err, rx_frame_err}, 2'b00);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        // 8N1 TX of 0xA5, divisor 4: 64 cycles per bit
        tx_base = tx_cnt;
        send_tx(8'hA5);
        chk("a5_start_line", uart_tx, 1'b0);
        chk("a5_busy", tx_ready, 1'b0);
        wait_tx_level(1'b1, 100, w);
        chk("a5_start_len", (w >= 64 && w <= 68), 1'b1);
        // Write during the frame must be ignored.
        tx_data = 8'hFF;
        tx_wr   = 1'b1;
        @(negedge sys_clk);
        tx_wr   = 1'b0;
        repeat (31) @(negedge sys_clk);
        exp_a5 = {1'b1, 8'hA5};
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("a5_bit%0d", k + 1), uart_tx, exp_a5[k]);
            if (k < 8) repeat (64) @(negedge sys_clk);
        end
        repeat (31) @(negedge sys_clk);
        chk("a5_done_early", tx_done, 1'b0);
        @(negedge sys_clk);
        chk("a5_done", tx_done, 1'b1);
        chk("a5_ready", tx_ready, 1'b1);
        // Write in the tx_done cycle is dropped.
        tx_data = 8'h00;
        tx_wr   = 1'b1;
        @(negedge sys_clk);
        tx_wr   = 1'b0;
        chk("done_cycle_wr_ready", tx_ready, 1'b1);
        chk("done_cycle_wr_line", uart_tx, 1'b1);
        repeat (100) @(negedge sys_clk);
        chk("a5_idle_line", uart_tx, 1'b1);
        chk("a5_one_done", tx_cnt - tx_base, 1);

        // Loopback 8E2 of 0x3C: parity bit 0, two stop bits
        parity_mode = 2'b01;
        stop2       = 1'b1;
        loop_en     = 1'b1;
        rx_base     = rx_cnt;
        tx_base     = tx_cnt;
        send_tx(8'h3C);
        wait_tx_level(1'b1, 300, w);
        chk("3c_first_rise", (w >= 192 && w <= 196), 1'b1);
        repeat (6 * 64 + 32) @(negedge sys_clk);
        chk("3c_parity_bit", uart_tx, 1'b0);
        repeat (64) @(negedge sys_clk);
        chk("3c_stop1", uart_tx, 1'b1);
        repeat (64) @(negedge sys_clk);
        chk("3c_stop2", uart_tx, 1'b1);
        repeat (31) @(negedge sys_clk);
        chk("3c_done_early", tx_done, 1'b0);
        @(negedge sys_clk);
        chk("3c_done", tx_done, 1'b1);
        repeat (100) @(negedge sys_clk);
        chk("3c_rx_count", rx_cnt - rx_base, 1);
        chk("3c_rx_data", rx_data, 8'h3C);
        chk("3c_flags", {rx_parity_err, rx_frame_err}, 2'b00);
        chk("3c_tx_count", tx_cnt - tx_base, 1);

        // 8O1 frame 0x01 with wrong parity bit 1
        loop_en     = 1'b0;
        parity_mode = 2'b10;
        stop2       = 1'b0;
        rx_base     = rx_cnt;
        drive_frame({5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
        repeat (64) @(negedge sys_clk);
        chk("perr_count", rx_cnt - rx_base, 1);
        chk("perr_data", rx_data, 8'h01);
        chk("perr_parity", rx_parity_err, 1'b1);
        chk("perr_frame", rx_frame_err, 1'b0);

        // Asynchronous reset mid-frame in both directions
        parity_mode = 2'b00;
        send_tx(8'h00);
        rx_drv = 1'b0;
        repeat (200) @(negedge sys_clk);
        chk("mid_frame_line", uart_tx, 1'b0);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("arst_uart_tx", uart_tx, 1'b1);
        chk("arst_tx_ready", tx_ready, 1'b1);
        chk("arst_rx_done", rx_done, 1'b0);
        chk("arst_flags", {rx_parity_err, rx_frame_err}, 2'b00);
        chk("arst_rx_data", rx_data, 8'h00);
        rx_drv = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);

        // Break: 20 bit times low gives one frame error, then recovery with 0x55
        rx_base = rx_cnt;
        rx_drv  = 1'b0;
        repeat (20 * 64) @(negedge sys_clk);
        chk("brk_count", rx_cnt - rx_base, 1);
        chk("brk_data", rx_data, 8'h00);
        chk("brk_frame", rx_frame_err, 1'b1);
        chk("brk_parity", rx_parity_err, 1'b0);
        rx_drv = 1'b1;
        repeat (64) @(negedge sys_clk);
        chk("brk_release_count", rx_cnt - rx_base, 1);
        drive_frame({6'b0, 1'b1, 8'h55, 1'b0}, 10);
        repeat (64) @(negedge sys_clk);
        chk("55_count", rx_cnt - rx_base, 2);
        chk("55_data", rx_data, 8'h55);
        chk("55_flags", {rx_parity_err, rx_frame_err}, 2'b00);

        // Glitch of 4 ticks is rejected
        rx_base = rx_cnt;
        rx_drv  = 1'b0;
        repeat (16) @(negedge sys_clk);
        rx_drv  = 1'b1;
        repeat (3 * 64) @(negedge sys_clk);
        chk("glitch_no_done", rx_cnt - rx_base, 0);
        chk("glitch_data_kept", rx_data, 8'h55);

        // Divisor 0 behaves as 1: 16-cycle bits, loopback of 0x96
        divisor = '0;
        loop_en = 1'b1;
        repeat (20) @(negedge sys_clk);
        rx_base = rx_cnt;
        send_tx(8'h96);
        wait_tx_level(1'b1, 60, w);
        chk("div0_first_rise", (w >= 32 && w <= 34), 1'b1);
        repeat (127) @(negedge sys_clk);
        chk("div0_done_early", tx_done, 1'b0);
        @(negedge sys_clk);
        chk("div0_done", tx_done, 1'b1);
        repeat (20) @(negedge sys_clk);
        chk("div0_rx_count", rx_cnt - rx_base, 1);
        chk("div0_rx_data", rx_data, 8'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
